// File: rtl/apb_requester.sv
// APB3 requester: turns a valid/ready command stream into SETUP/ACCESS transfers
// and returns read data and timeout status on a valid/ready response stream.
module apb_requester #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_write,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [ADDR_W-1:0] paddr,
  output logic              pwrite,
  output logic              psel,
  output logic              penable,
  output logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              pready
);

  localparam int unsigned CNT_W = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam bit TIMEOUT_EN = (TIMEOUT != 0);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2
  } state_t;

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_psel;
  logic              r_penable;
  logic              r_pwrite;
  logic [ADDR_W-1:0] r_paddr;
  logic [DATA_W-1:0] r_pwdata;
  logic              r_rsp_valid;
  logic              r_rsp_write;
  logic [DATA_W-1:0] r_rsp_rdata;
  logic              r_rsp_err;

  state_t            w_state_nxt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic              w_psel_nxt;
  logic              w_penable_nxt;
  logic              w_pwrite_nxt;
  logic [ADDR_W-1:0] w_paddr_nxt;
  logic [DATA_W-1:0] w_pwdata_nxt;
  logic              w_rsp_valid_nxt;
  logic              w_rsp_write_nxt;
  logic [DATA_W-1:0] w_rsp_rdata_nxt;
  logic              w_rsp_err_nxt;
  logic              w_cmd_ready;
  logic              w_accept;

  // Only unregistered output: a new command waits until the previous response is retired.
  assign w_cmd_ready = (r_state == S_IDLE) && !r_rsp_valid && !rst;
  assign w_accept    = cmd_valid && w_cmd_ready;

  // Next-state and next-output logic.
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_psel_nxt      = r_psel;
    w_penable_nxt   = r_penable;
    w_pwrite_nxt    = r_pwrite;
    w_paddr_nxt     = r_paddr;
    w_pwdata_nxt    = r_pwdata;
    w_rsp_valid_nxt = r_rsp_valid;
    w_rsp_write_nxt = r_rsp_write;
    w_rsp_rdata_nxt = r_rsp_rdata;
    w_rsp_err_nxt   = r_rsp_err;

    if (r_rsp_valid && rsp_ready) begin
      w_rsp_valid_nxt = 1'b0;
      w_rsp_write_nxt = 1'b0;
      w_rsp_rdata_nxt = '0;
      w_rsp_err_nxt   = 1'b0;
    end

    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          w_paddr_nxt  = cmd_addr;
          w_pwrite_nxt = cmd_write;
          w_pwdata_nxt = cmd_wdata;
          w_cnt_nxt    = '0;
          w_state_nxt  = S_SETUP;
        end
      end
      S_SETUP: begin
        w_psel_nxt    = 1'b1;
        w_penable_nxt = 1'b0;
        w_state_nxt   = S_ACCESS;
      end
      S_ACCESS: begin
        // First ACCESS cycle raises penable; completer is sampled only once it is high.
        if (!r_penable) begin
          w_penable_nxt = 1'b1;
        end else if (pready) begin
          w_psel_nxt      = 1'b0;
          w_penable_nxt   = 1'b0;
          w_rsp_valid_nxt = 1'b1;
          w_rsp_write_nxt = r_pwrite;
          w_rsp_rdata_nxt = r_pwrite ? '0 : prdata;
          w_rsp_err_nxt   = 1'b0;
          w_state_nxt     = S_IDLE;
        end else if (TIMEOUT_EN && (r_cnt == CNT_LAST)) begin
          w_psel_nxt      = 1'b0;
          w_penable_nxt   = 1'b0;
          w_rsp_valid_nxt = 1'b1;
          w_rsp_write_nxt = r_pwrite;
          w_rsp_rdata_nxt = '0;
          w_rsp_err_nxt   = 1'b1;
          w_state_nxt     = S_IDLE;
        end else if (r_cnt != CNT_MAX) begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_psel_nxt    = 1'b0;
        w_penable_nxt = 1'b0;
        w_state_nxt   = S_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_psel      <= 1'b0;
      r_penable   <= 1'b0;
      r_pwrite    <= 1'b0;
      r_paddr     <= '0;
      r_pwdata    <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_write <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_psel      <= w_psel_nxt;
      r_penable   <= w_penable_nxt;
      r_pwrite    <= w_pwrite_nxt;
      r_paddr     <= w_paddr_nxt;
      r_pwdata    <= w_pwdata_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_write <= w_rsp_write_nxt;
      r_rsp_rdata <= w_rsp_rdata_nxt;
      r_rsp_err   <= w_rsp_err_nxt;
    end
  end

  assign cmd_ready = w_cmd_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_write = r_rsp_write;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;
  assign paddr     = r_paddr;
  assign pwrite    = r_pwrite;
  assign psel      = r_psel;
  assign penable   = r_penable;
  assign pwdata    = r_pwdata;

endmodule

// File: tb/tb_apb_requester.sv
// Directed bench for apb_requester against a small memory-backed APB completer model
// with programmable wait states.
module tb_apb_requester;

  logic        clk;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [7:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_write;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [7:0]  paddr;
  logic        pwrite;
  logic        psel;
  logic        penable;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;

  int checks = 0;
  int errors = 0;

  int unsigned wait_n = 0;
  bit          never_ready = 1'b0;
  int unsigned acc_cnt = 0;
  logic [31:0] mem [256];

  apb_requester #(.ADDR_W(8), .DATA_W(32), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .paddr(paddr), .pwrite(pwrite), .psel(psel), .penable(penable),
    .pwdata(pwdata), .prdata(prdata), .pready(pready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Completer model: ready after wait_n ACCESS cycles; prdata is junk unless completing.
  always_comb pready = psel && penable && !never_ready && (acc_cnt >= wait_n);
  always_comb prdata = (psel && penable && pready) ? mem[paddr] : 32'hBAD0_BAD0;

  always @(posedge clk) begin
    if (psel && penable && !pready) acc_cnt <= acc_cnt + 1;
    else                            acc_cnt <= 0;
    if (psel && penable && pready && pwrite) mem[paddr] <= pwdata;
  end

  // Protocol monitor.
  bit          prev_setup = 1'b0;
  bit          prev_wait = 1'b0;
  logic [7:0]  prev_addr = '0;
  logic        prev_wr = 1'b0;
  logic [31:0] prev_wd = '0;

  always @(negedge clk) begin
    if (rst) begin
      prev_setup = 1'b0;
      prev_wait  = 1'b0;
    end else begin
      if (penable) begin
        checks++;
        if (!psel) begin
          errors++;
          $display("FAIL apb_penable_without_psel got psel=%0b exp 1", psel);
        end
      end
      if (prev_setup) begin
        checks++;
        if (!(psel && penable)) begin
          errors++;
          $display("FAIL apb_setup_to_access got psel=%0b penable=%0b exp 1 1", psel, penable);
        end
      end
      if ((prev_setup || prev_wait) && psel) begin
        checks++;
        if (paddr !== prev_addr || pwrite !== prev_wr || pwdata !== prev_wd) begin
          errors++;
          $display("FAIL apb_stable got addr=%h wr=%0b wd=%h exp addr=%h wr=%0b wd=%h",
                   paddr, pwrite, pwdata, prev_addr, prev_wr, prev_wd);
        end
      end
      prev_setup = psel && !penable;
      prev_wait  = psel && penable && !pready;
      prev_addr  = paddr;
      prev_wr    = pwrite;
      prev_wd    = pwdata;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Waits for rsp_valid; ok=0 if it never arrives.
  task automatic wait_rsp(output bit ok);
    ok = 1'b0;
    for (int n = 0; n < 50; n++) begin
      if (rsp_valid) begin
        ok = 1'b1;
        return;
      end
      tick();
    end
  endtask

  // Full transaction: issue command, collect response (optionally with random rsp_ready).
  task automatic run_txn(input bit wr, input logic [7:0] a, input logic [31:0] d,
                         input bit rnd_rdy, output logic [31:0] rd, output bit err,
                         output bit ok);
    bit sent;
    ok = 1'b0;
    rd = '0;
    err = 1'b0;
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = a;
    cmd_wdata = d;
    for (int n = 0; n < 50 && !cmd_ready; n++) tick();
    if (!cmd_ready) begin
      cmd_valid = 1'b0;
      return;
    end
    tick();
    cmd_valid = 1'b0;
    for (int n = 0; n < 200; n++) begin
      sent = 1'b0;
      if (rsp_valid) begin
        rd = rsp_rdata;
        err = rsp_err;
        rsp_ready = rnd_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        sent = rsp_ready;
      end else begin
        rsp_ready = 1'b0;
      end
      tick();
      if (sent) begin
        rsp_ready = 1'b0;
        ok = 1'b1;
        return;
      end
    end
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr = 8'h55;
    cmd_wdata = 32'h1111_2222;
    rsp_ready = 1'b0;
    tick();
    tick();
    checks++;
    if (cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_cmd_ready got %0b exp 0", cmd_ready);
    end
    checks++;
    if ({psel, penable, pwrite, rsp_valid, rsp_err, rsp_write} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl got psel=%0b pen=%0b pwr=%0b rv=%0b re=%0b rw=%0b exp all 0",
               psel, penable, pwrite, rsp_valid, rsp_err, rsp_write);
    end
    checks++;
    if (paddr !== 8'h0 || pwdata !== 32'h0 || rsp_rdata !== 32'h0) begin
      errors++;
      $display("FAIL reset_data got paddr=%h pwdata=%h rdata=%h exp 0", paddr, pwdata, rsp_rdata);
    end
    cmd_valid = 1'b0;
    rst = 1'b0;
    #1;
    checks++;
    if (cmd_ready !== 1'b1 || psel !== 1'b0) begin
      errors++;
      $display("FAIL reset_release got cmd_ready=%0b psel=%0b exp 1 0", cmd_ready, psel);
    end
  endtask

  task automatic test_write_zero_wait;
    wait_n = 0;
    never_ready = 1'b0;
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr = 8'h10;
    cmd_wdata = 32'hDEAD_BEEF;
    checks++;
    if (cmd_ready !== 1'b1) begin
      errors++;
      $display("FAIL t1_cmd_ready got %0b exp 1", cmd_ready);
    end
    tick();
    cmd_valid = 1'b0;
    checks++;
    if (psel !== 1'b0 || cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL t1_edgeN got psel=%0b cmd_ready=%0b exp 0 0", psel, cmd_ready);
    end
    tick();
    checks++;
    if ({psel, penable} !== 2'b10) begin
      errors++;
      $display("FAIL t1_setup got psel/penable=%b exp 10", {psel, penable});
    end
    checks++;
    if (paddr !== 8'h10 || pwrite !== 1'b1 || pwdata !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL t1_bus got paddr=%h pwrite=%0b pwdata=%h exp 10 1 deadbeef",
               paddr, pwrite, pwdata);
    end
    tick();
    checks++;
    if ({psel, penable, rsp_valid} !== 3'b110) begin
      errors++;
      $display("FAIL t1_access got psel/penable/rsp_valid=%b exp 110", {psel, penable, rsp_valid});
    end
    tick();
    checks++;
    if ({psel, penable, rsp_valid} !== 3'b001) begin
      errors++;
      $display("FAIL t1_done got psel/penable/rsp_valid=%b exp 001", {psel, penable, rsp_valid});
    end
    checks++;
    if (rsp_err !== 1'b0 || rsp_rdata !== 32'h0 || rsp_write !== 1'b1) begin
      errors++;
      $display("FAIL t1_rsp got err=%0b rdata=%h write=%0b exp 0 0 1", rsp_err, rsp_rdata, rsp_write);
    end
    checks++;
    if (mem[8'h10] !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL t1_mem got %h exp deadbeef", mem[8'h10]);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL t1_retire got rsp_valid=%0b exp 0", rsp_valid);
    end
  endtask

  task automatic test_read_wait;
    wait_n = 2;
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr = 8'h10;
    cmd_wdata = 32'h0;
    tick();
    cmd_valid = 1'b0;
    tick();
    tick();
    for (int k = 0; k < 2; k++) begin
      tick();
      checks++;
      if ({psel, penable, rsp_valid} !== 3'b110 || paddr !== 8'h10) begin
        errors++;
        $display("FAIL t2_wait%0d got psel/pen/rv=%b paddr=%h exp 110 10",
                 k, {psel, penable, rsp_valid}, paddr);
      end
    end
    tick();
    checks++;
    if ({psel, penable, rsp_valid} !== 3'b001) begin
      errors++;
      $display("FAIL t2_done got psel/pen/rv=%b exp 001", {psel, penable, rsp_valid});
    end
    checks++;
    if (rsp_rdata !== 32'hDEAD_BEEF || rsp_err !== 1'b0 || rsp_write !== 1'b0) begin
      errors++;
      $display("FAIL t2_rsp got rdata=%h err=%0b write=%0b exp deadbeef 0 0",
               rsp_rdata, rsp_err, rsp_write);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_timeout;
    logic [31:0] rd;
    bit err;
    bit ok;
    never_ready = 1'b1;
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr = 8'h10;
    tick();
    cmd_valid = 1'b0;
    tick();
    tick();
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if ({psel, penable, rsp_valid} !== 3'b110) begin
        errors++;
        $display("FAIL t3_access%0d got psel/pen/rv=%b exp 110", k + 1, {psel, penable, rsp_valid});
      end
    end
    tick();
    checks++;
    if ({psel, penable, rsp_valid} !== 3'b001) begin
      errors++;
      $display("FAIL t3_abort got psel/pen/rv=%b exp 001", {psel, penable, rsp_valid});
    end
    checks++;
    if (rsp_err !== 1'b1 || rsp_rdata !== 32'h0) begin
      errors++;
      $display("FAIL t3_rsp got err=%0b rdata=%h exp 1 0", rsp_err, rsp_rdata);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    never_ready = 1'b0;
    wait_n = 1;
    run_txn(1'b0, 8'h10, 32'h0, 1'b0, rd, err, ok);
    checks++;
    if (!ok || rd !== 32'hDEAD_BEEF || err !== 1'b0) begin
      errors++;
      $display("FAIL t3_recover got ok=%0b rdata=%h err=%0b exp 1 deadbeef 0", ok, rd, err);
    end
  endtask

  task automatic test_rsp_backpressure;
    bit ok;
    wait_n = 0;
    cmd_valid = 1'b1;
    cmd_write = 1'b1;
    cmd_addr = 8'h30;
    cmd_wdata = 32'h1234_5678;
    tick();
    cmd_valid = 1'b0;
    wait_rsp(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL t4_first_rsp got rsp_valid=%0b exp 1", rsp_valid);
    end
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr = 8'h30;
    cmd_wdata = 32'h0;
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (cmd_ready !== 1'b0 || psel !== 1'b0 || rsp_valid !== 1'b1 || rsp_write !== 1'b1 ||
          rsp_rdata !== 32'h0 || rsp_err !== 1'b0) begin
        errors++;
        $display("FAIL t4_hold%0d got cr=%0b psel=%0b rv=%0b rw=%0b rd=%h re=%0b exp 0 0 1 1 0 0",
                 k, cmd_ready, psel, rsp_valid, rsp_write, rsp_rdata, rsp_err);
      end
      tick();
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    checks++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1 || psel !== 1'b0) begin
      errors++;
      $display("FAIL t4_retire got rv=%0b cr=%0b psel=%0b exp 0 1 0", rsp_valid, cmd_ready, psel);
    end
    tick();
    cmd_valid = 1'b0;
    checks++;
    if (cmd_ready !== 1'b0) begin
      errors++;
      $display("FAIL t4_accept got cmd_ready=%0b exp 0", cmd_ready);
    end
    wait_rsp(ok);
    checks++;
    if (!ok || rsp_rdata !== 32'h1234_5678 || rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL t4_read got ok=%0b rdata=%h err=%0b exp 1 12345678 0", ok, rsp_rdata, rsp_err);
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset_mid;
    logic [31:0] rd;
    bit err;
    bit ok;
    wait_n = 0;
    run_txn(1'b1, 8'h20, 32'hCAFE_F00D, 1'b0, rd, err, ok);
    checks++;
    if (!ok || err !== 1'b0) begin
      errors++;
      $display("FAIL t5_write got ok=%0b err=%0b exp 1 0", ok, err);
    end
    wait_n = 2;
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr = 8'h20;
    tick();
    cmd_valid = 1'b0;
    tick();
    tick();
    tick();
    checks++;
    if ({psel, penable} !== 2'b11) begin
      errors++;
      $display("FAIL t5_in_access got psel/penable=%b exp 11", {psel, penable});
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({psel, penable, rsp_valid, cmd_ready} !== 4'b0000) begin
      errors++;
      $display("FAIL t5_async got psel/pen/rv/cr=%b exp 0000", {psel, penable, rsp_valid, cmd_ready});
    end
    tick();
    tick();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      checks++;
      if (rsp_valid !== 1'b0 || psel !== 1'b0) begin
        errors++;
        $display("FAIL t5_lost%0d got rsp_valid=%0b psel=%0b exp 0 0", k, rsp_valid, psel);
      end
    end
    run_txn(1'b0, 8'h20, 32'h0, 1'b0, rd, err, ok);
    checks++;
    if (!ok || rd !== 32'hCAFE_F00D || err !== 1'b0) begin
      errors++;
      $display("FAIL t5_read got ok=%0b rdata=%h err=%0b exp 1 cafef00d 0", ok, rd, err);
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0]  a;
    logic [31:0] d;
    logic [31:0] rd;
    bit err;
    bit ok;
    for (int i = 0; i < 256; i++) begin
      a = 8'($urandom_range(0, 255));
      d = $urandom;
      wait_n = $urandom_range(0, 2);
      run_txn(1'b1, a, d, 1'b1, rd, err, ok);
      checks++;
      if (!ok || err !== 1'b0 || rd !== 32'h0) begin
        errors++;
        $display("FAIL b2b_write%0d got ok=%0b err=%0b rdata=%h exp 1 0 0", i, ok, err, rd);
      end
      wait_n = $urandom_range(0, 2);
      run_txn(1'b0, a, 32'h0, 1'b1, rd, err, ok);
      checks++;
      if (!ok || err !== 1'b0 || rd !== d) begin
        errors++;
        $display("FAIL b2b_read%0d addr=%h got ok=%0b err=%0b rdata=%h exp 1 0 %h",
                 i, a, ok, err, rd, d);
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr = '0;
    cmd_wdata = '0;
    rsp_ready = 1'b0;
    test_reset();
    test_write_zero_wait();
    test_read_wait();
    test_timeout();
    test_rsp_backpressure();
    test_reset_mid();
    test_back_to_back();
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
